// File: rtl/img_pkg.sv
// Shared constants, FSM state type and raster-order helper for the image streamer.
package img_pkg;
   localparam int ADDR_W  = 6;
   localparam int PIX_W   = 24;
   localparam int IMG_DIM = 1 << ADDR_W;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
      logic              last_col;
      logic              last_frame;
   } raster_t;

   function automatic raster_t raster_next(input logic [ADDR_W-1:0] row,
                                           input logic [ADDR_W-1:0] col);
      raster_t r;
      r.last_col   = (col == ADDR_W'(IMG_DIM - 1));
      r.last_frame = r.last_col && (row == ADDR_W'(IMG_DIM - 1));
      r.col        = col + 1'b1;
      r.row        = r.last_col ? row + 1'b1 : row;
      return r;
   endfunction
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO with a registered head; push while full is only legal with a pop.
module stream_fifo2 #(
   parameter int W = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic [1:0]   count_o
);
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [1:0]   count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop_i && count_q != 2'd0) begin
         if (count_q == 2'd2) begin
            head_d = tail_q;
            if (push_i) tail_d = din_i;
            else        count_d = 2'd1;
         end else if (push_i) begin
            head_d = din_i;
         end else begin
            count_d = 2'd0;
         end
      end else if (push_i && count_q != 2'd2) begin
         if (count_q == 2'd0) head_d = din_i;
         else                 tail_d = din_i;
         count_d = count_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = head_q;
   assign count_o = count_q;
endmodule

// File: rtl/image_streamer.sv
// Reads the 64x64 processed image in raster order and streams it out with
// line/frame markers once per rising edge of start.
module image_streamer
   import img_pkg::*;
#(
   parameter int GRAY_EXPAND = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] row,
   output logic [ADDR_W-1:0] col,
   input  logic [PIX_W-1:0]  in_pix,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [PIX_W-1:0]  m_data,
   output logic              m_eol,
   output logic              m_eof,
   output logic              done
);
   state_e            state_q;
   logic              start_q;
   logic [ADDR_W-1:0] row_q, col_q;
   logic              done_q;
   logic [1:0]        count;
   logic [PIX_W+1:0]  head, din;
   logic [PIX_W-1:0]  pix_x;
   logic              launch, pop, push;
   raster_t           rn;

   assign launch = start & ~start_q;
   assign pop    = m_valid & m_ready;
   assign push   = (state_q == RUN) && ((count < 2'd2) || pop);
   assign rn     = raster_next(row_q, col_q);
   assign pix_x  = (GRAY_EXPAND != 0) ? {3{in_pix[G_HI:G_LO]}} : in_pix;
   assign din    = {pix_x, rn.last_col, rn.last_frame};

   stream_fifo2 #(.W(PIX_W + 2)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (din),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count)
   );

   // start_q resets high so a start already asserted at reset release is not an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= 1'b1;
         row_q   <= '0;
         col_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         start_q <= start;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  state_q <= RUN;
                  row_q   <= '0;
                  col_q   <= '0;
               end
            end
            RUN: begin
               if (push) begin
                  if (rn.last_frame) begin
                     state_q <= DRAIN;
                  end else begin
                     row_q <= rn.row;
                     col_q <= rn.col;
                  end
               end
            end
            DRAIN: begin
               if (count == 2'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  row_q   <= '0;
                  col_q   <= '0;
               end
            end
            DONE: begin
               if (launch) begin
                  state_q <= RUN;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign row     = row_q;
   assign col     = col_q;
   assign done    = done_q;
   assign m_valid = (count != 2'd0);
   assign m_data  = head[PIX_W+1:2];
   assign m_eol   = head[1];
   assign m_eof   = head[0];
endmodule

// File: tb/tb_image_streamer.sv
// Bench for image_streamer: index-based raster model checked every cycle, plus directed scenarios.
module tb_image_streamer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        rst, start, m_ready, m_valid, m_eol, m_eof, done;
   logic [5:0]  row, col;
   logic [23:0] in_pix, m_data;
   logic        g_rst, g_start, g_ready, g_valid, g_eol, g_eof, g_done;
   logic [5:0]  g_row, g_col;
   logic [23:0] g_pix, g_data;

   function automatic logic [23:0] pix0(input int r, input int c);
      return {8'(r), 8'(c), 8'(r ^ c)};
   endfunction

   function automatic logic [23:0] pixg(input int r, input int c);
      if (r == 0 && c == 0)   return 24'h12AB34;
      if (r == 63 && c == 63) return 24'h00FF00;
      return pix0(r, c);
   endfunction

   function automatic logic [23:0] gexp(input logic [23:0] p);
      return {p[15:8], p[15:8], p[15:8]};
   endfunction

   assign in_pix = pix0(int'(row), int'(col));
   assign g_pix  = pixg(int'(g_row), int'(g_col));

   image_streamer #(.GRAY_EXPAND(0)) dut (
      .clk(clk), .rst(rst), .start(start), .row(row), .col(col), .in_pix(in_pix),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_eol(m_eol),
      .m_eof(m_eof), .done(done)
   );

   image_streamer #(.GRAY_EXPAND(1)) dut_g (
      .clk(clk), .rst(g_rst), .start(g_start), .row(g_row), .col(g_col), .in_pix(g_pix),
      .m_valid(g_valid), .m_ready(g_ready), .m_data(g_data), .m_eol(g_eol),
      .m_eof(g_eof), .done(g_done)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   int          exp_k = 0, frames = 0, eol_cnt = 0, first_cyc = 0, eof_cyc = 0;
   int          g_k = 0, g_frames = 0;
   logic        done_pend = 1'b0, prev_stall = 1'b0, prev_eol = 1'b0, prev_eof = 1'b0;
   logic [23:0] prev_data = '0;
   logic        sim_end = 1'b0;

   initial begin
      rst = 1'b1; start = 1'b1; m_ready = 1'b1;
      g_rst = 1'b1; g_start = 1'b0; g_ready = 1'b1;
      fork
         begin : compare
            while (!sim_end) begin
               @(negedge clk);
               if (rst) begin
                  exp_k = 0; eol_cnt = 0; prev_stall = 1'b0; done_pend = 1'b0;
               end else begin
                  if (done_pend && cyc == eof_cyc + 1) check("done_not_early", 32'(done), 0);
                  if (done_pend && cyc == eof_cyc + 2) begin
                     check("done_after_eof", 32'(done), 1);
                     done_pend = 1'b0;
                  end
                  if (prev_stall) begin
                     check("stall_valid", 32'(m_valid), 1);
                     check("stall_data", 32'(m_data), 32'(prev_data));
                     check("stall_marks", 32'({m_eol, m_eof}), 32'({prev_eol, prev_eof}));
                  end
                  if (m_valid && m_ready) begin
                     check("beat_data", 32'(m_data), 32'(pix0(exp_k / 64, exp_k % 64)));
                     check("beat_eol", 32'(m_eol), 32'(exp_k % 64 == 63));
                     check("beat_eof", 32'(m_eof), 32'(exp_k == 4095));
                     if (exp_k == 65)   check("lit_beat65", 32'(m_data), 32'h010100);
                     if (exp_k == 4095) check("lit_last", 32'(m_data), 32'h3F3F00);
                     if (m_eol) eol_cnt++;
                     if (exp_k == 0) first_cyc = cyc;
                     if (exp_k == 4095) begin
                        check("eol_per_frame", 32'(eol_cnt), 64);
                        eof_cyc = cyc; done_pend = 1'b1;
                        frames++; exp_k = 0; eol_cnt = 0;
                     end else begin
                        exp_k++;
                     end
                  end
                  prev_stall = m_valid && !m_ready;
                  prev_data = m_data; prev_eol = m_eol; prev_eof = m_eof;
               end
               if (!g_rst && g_valid && g_ready) begin
                  check("g_data", 32'(g_data), 32'(gexp(pixg(g_k / 64, g_k % 64))));
                  check("g_eol", 32'(g_eol), 32'(g_k % 64 == 63));
                  check("g_eof", 32'(g_eof), 32'(g_k == 4095));
                  if (g_k == 0) check("lit_gray_first", 32'(g_data), 32'hABABAB);
                  if (g_k == 4095) begin
                     check("lit_gray_last", 32'({g_data, g_eol, g_eof}), 32'({24'hFFFFFF, 2'b11}));
                     g_frames++; g_k = 0;
                  end else begin
                     g_k++;
                  end
               end
            end
         end
         begin : driver
            int bud, gl_t;
            logic glitched;
            logic [5:0] rr, cc;
            @(posedge clk); #2;
            check("rst_row", 32'(row), 0);
            check("rst_col", 32'(col), 0);
            check("rst_valid", 32'(m_valid), 0);
            check("rst_data", 32'(m_data), 0);
            check("rst_marks", 32'({m_eol, m_eof}), 0);
            check("rst_done", 32'(done), 0);
            @(posedge clk); #1 rst = 1'b0; g_rst = 1'b0;
            @(posedge clk); #1 g_start = 1'b1;
            repeat (20) @(posedge clk);
            #1 check("no_launch_start_high", 32'(frames + exp_k + 32'(m_valid)), 0);
            check("idle_done_low", 32'(done), 0);

            bud = 0;
            while (g_frames < 1 && bud < 6000) begin @(posedge clk); bud++; end
            check("gray_frame_done", 32'(g_frames), 1);

            // full-speed frame
            @(posedge clk); #1 start = 1'b0;
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); @(negedge clk) check("latency_run_no_valid", 32'(m_valid), 0);
            @(posedge clk); @(negedge clk) check("latency_first_valid", 32'(m_valid), 1);
            check("lit_first_pix", 32'(m_data), 0);
            bud = 0;
            while (frames < 1 && bud < 6000) begin @(posedge clk); bud++; end
            check("frame1_done", 32'(frames), 1);
            check("frame1_contiguous", 32'(eof_cyc - first_cyc), 4095);
            repeat (3) @(posedge clk);
            #1 check("done_held", 32'(done), 1);

            // start held high: no second frame
            repeat (5000) @(posedge clk);
            #1 check("no_relaunch_held", 32'(frames * 8192 + exp_k + 32'(m_valid)), 8192);
            check("done_still_high", 32'(done), 1);

            // relaunch with backpressure and a start glitch mid-frame
            start = 1'b0;
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 check("done_clr_at_launch", 32'(done), 0);
            bud = 0;
            while (exp_k < 100 && bud < 1000) begin @(posedge clk); bud++; end
            check("reach_beat100", 32'(exp_k >= 100), 1);
            #1 m_ready = 1'b0;
            rr = '0; cc = '0;
            for (int i = 0; i < 10; i++) begin
               @(posedge clk); #1;
               if (i == 3) begin rr = row; cc = col; end
               else if (i > 3) begin
                  check("stall_row_frozen", 32'(row), 32'(rr));
                  check("stall_col_frozen", 32'(col), 32'(cc));
               end
            end
            bud = 0; glitched = 1'b0; gl_t = 0;
            while (frames < 2 && bud < 20000) begin
               @(posedge clk); #1;
               m_ready = 1'($urandom_range(0, 1));
               if (!glitched && exp_k >= 500) begin start = 1'b0; gl_t = bud; glitched = 1'b1; end
               else if (glitched && bud == gl_t + 1) start = 1'b1;
               bud++;
            end
            check("frame2_done", 32'(frames), 2);
            m_ready = 1'b1;
            repeat (3) @(posedge clk);

            // reset mid-frame, then relaunch
            start = 1'b0;
            @(posedge clk); #1 start = 1'b1;
            bud = 0;
            while (exp_k < 1000 && bud < 2000) begin @(posedge clk); bud++; end
            check("reach_beat1000", 32'(exp_k >= 1000), 1);
            #1 rst = 1'b1;
            #1 check("midrst_valid", 32'(m_valid), 0);
            check("midrst_done", 32'(done), 0);
            check("midrst_row", 32'(row), 0);
            check("midrst_col", 32'(col), 0);
            @(posedge clk); @(posedge clk); #1 rst = 1'b0;
            start = 1'b0;
            @(posedge clk); #1 start = 1'b1;
            bud = 0;
            while (frames < 3 && bud < 6000) begin @(posedge clk); bud++; end
            check("frame3_done", 32'(frames), 3);
            repeat (3) @(posedge clk);
            sim_end = 1'b1;
         end
      join
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
